// File: rtl/map_pkg.sv
// Shared constants and types for the tile map: geometry, scheduler states and requester ids.
// Used by the access scheduler, the map memory and the renderer.
package map_pkg;

  localparam int unsigned TILE_PX  = 60;
  localparam int unsigned COLS     = 14;
  localparam int unsigned ROWS     = 8;
  localparam int unsigned AW       = 3;

  // Pixel remainders cover an 11-bit x; quotients top out at COLS-1 = 13.
  localparam int unsigned REM_W    = 11;
  localparam int unsigned QUO_W    = 4;

  localparam int unsigned MAP_W_PX = COLS * TILE_PX;
  localparam int unsigned MAP_H_PX = ROWS * TILE_PX;

  typedef enum logic [2:0] {
    StIdle,
    StDiv,
    StRead,
    StWait,
    StDone
  } state_e;

  typedef enum logic {
    GntVid,
    GntCol
  } grant_e;

  function automatic logic px_in_range(input logic [REM_W-1:0] px, input int unsigned limit);
    return 32'(px) < limit;
  endfunction

endpackage

// File: rtl/tile_divider.sv
// Iterative divide-by-TILE_PX for one axis: one subtraction per enabled cycle until the
// remainder drops below a tile edge.
module tile_divider
  import map_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [REM_W-1:0] value,
  output logic [QUO_W-1:0] quotient,
  output logic [REM_W-1:0] remainder,
  output logic             done
);

  localparam logic [REM_W-1:0] TileEdge = REM_W'(TILE_PX);

  logic [REM_W-1:0] rem_q, rem_d;
  logic [QUO_W-1:0] quo_q, quo_d;

  assign done      = rem_q < TileEdge;
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    if (start) begin
      rem_d = value;
      quo_d = '0;
    end else if (step && !done) begin
      rem_d = rem_q - TileEdge;
      quo_d = quo_q + QUO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

endmodule

// File: rtl/map_access_scheduler.sv
// Arbitrates the single-read-port tile map between the video row fetcher and the ant collision
// checker, converting pixel coordinates to tile indices and returning results with valid pulses.
module map_access_scheduler
  import map_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            vid_req,
  input  logic [8:0]      vid_row,
  output logic            vid_ack,
  output logic            vid_valid,
  output logic [COLS-1:0] vid_tiles,
  input  logic            col_req,
  input  logic [10:0]     col_x,
  input  logic [10:0]     col_y,
  output logic            col_ack,
  output logic            col_valid,
  output logic            col_tile,
  output logic            mem_rd,
  output logic [AW-1:0]   mem_addr,
  input  logic [COLS-1:0] mem_data,
  output logic            busy
);

  state_e          state_q, state_d;
  grant_e          last_q, last_d;
  grant_e          cur_q, cur_d;
  logic [COLS-1:0] vid_tiles_q, vid_tiles_d;
  logic            col_tile_q, col_tile_d;

  logic             grant_vid, grant_col;
  logic             vid_in_range, col_in_range;
  logic             div_start, div_step;
  logic [REM_W-1:0] div_x_value, div_y_value;
  logic [QUO_W-1:0] quo_x, quo_y;
  logic [REM_W-1:0] rem_x, rem_y;
  logic             done_x, done_y;
  logic [QUO_W-1:0] tile_idx;

  // On a tie the requester that did not win last time goes first; reset leaves COL as last.
  always_comb begin
    grant_vid = (state_q == StIdle) && !reset && vid_req && (!col_req || last_q == GntCol);
    grant_col = (state_q == StIdle) && !reset && col_req && (!vid_req || last_q == GntVid);
  end

  assign vid_in_range = px_in_range(REM_W'(vid_row), MAP_H_PX);
  assign col_in_range = px_in_range(col_x, MAP_W_PX) && px_in_range(col_y, MAP_H_PX);

  // Video only needs the row index; the x divider is parked at zero so it reports done at once.
  assign div_x_value = grant_col ? col_x : '0;
  assign div_y_value = grant_col ? col_y : REM_W'(vid_row);
  assign div_step    = (state_q == StDiv);

  tile_divider u_div_x (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .step      (div_step),
    .value     (div_x_value),
    .quotient  (quo_x),
    .remainder (rem_x),
    .done      (done_x)
  );

  tile_divider u_div_y (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .step      (div_step),
    .value     (div_y_value),
    .quotient  (quo_y),
    .remainder (rem_y),
    .done      (done_y)
  );

  // Bit COLS-1 of a map word is the leftmost column.
  assign tile_idx = QUO_W'(COLS - 1) - quo_x;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cur_d       = cur_q;
    vid_tiles_d = vid_tiles_q;
    col_tile_d  = col_tile_q;
    div_start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_vid) begin
          last_d = GntVid;
          cur_d  = GntVid;
          if (vid_in_range) begin
            div_start = 1'b1;
            state_d   = StDiv;
          end else begin
            vid_tiles_d = '0;
            state_d     = StDone;
          end
        end else if (grant_col) begin
          last_d = GntCol;
          cur_d  = GntCol;
          if (col_in_range) begin
            div_start = 1'b1;
            state_d   = StDiv;
          end else begin
            // Off-map counts as solid so ants cannot walk out of the world.
            col_tile_d = 1'b1;
            state_d    = StDone;
          end
        end
      end
      StDiv: begin
        if (done_x && done_y) begin
          state_d = StRead;
        end
      end
      StRead: begin
        state_d = StWait;
      end
      StWait: begin
        if (cur_q == GntVid) begin
          vid_tiles_d = mem_data;
        end else begin
          col_tile_d = mem_data[tile_idx];
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      last_q      <= GntCol;
      cur_q       <= GntVid;
      vid_tiles_q <= '0;
      col_tile_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cur_q       <= cur_d;
      vid_tiles_q <= vid_tiles_d;
      col_tile_q  <= col_tile_d;
    end
  end

  assign vid_ack   = grant_vid;
  assign col_ack   = grant_col;
  assign vid_valid = (state_q == StDone) && (cur_q == GntVid);
  assign col_valid = (state_q == StDone) && (cur_q == GntCol);
  assign vid_tiles = vid_tiles_q;
  assign col_tile  = col_tile_q;
  assign mem_rd    = (state_q == StRead);
  assign mem_addr  = (state_q == StRead) ? quo_y[AW-1:0] : '0;
  assign busy      = (state_q != StIdle);

  // Remainders are only needed inside the dividers; qy never exceeds ROWS-1 after the range check.
  logic unused_div;
  assign unused_div = ^{rem_x, rem_y, quo_y[QUO_W-1]};

endmodule
